// File: rtl/pe_packetizer_if.sv
// Stream bundle for pe_packetizer: PE result words in, router flits out.
interface pe_packetizer_if #(
    parameter int DW = 32
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    // master: the side that supplies PE words and sinks flits
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // slave: the packetizer itself
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/pe_packetizer.sv
// pe_packetizer: wraps every PKT_LEN-1 PE result words into one NoC packet
// (head flit carrying the route, then body flits, the last one typed tail).
// A single output register holds the flit presented to the router.
module pe_packetizer #(
    parameter int DW      = 32,
    parameter int PKT_LEN = 4,
    parameter int X       = 0,
    parameter int Y       = 0,
    parameter int DEST_X  = 0,
    parameter int DEST_Y  = 0
) (
    input  logic        clk,
    input  logic        rst,
    pe_packetizer_if.slave bus,
    output logic        busy,
    output logic [15:0] pkt_cnt
);

    // cnt only ever reaches PKT_LEN-2, so PKT_LEN-1 distinct values
    localparam int CW = (PKT_LEN > 2) ? $clog2(PKT_LEN - 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 2);

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b10;

    localparam logic [3:0] SRC_X = 4'(X);
    localparam logic [3:0] SRC_Y = 4'(Y);
    localparam logic [3:0] DST_X = 4'(DEST_X);
    localparam logic [3:0] DST_Y = 4'(DEST_Y);

    typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] head_flit, flit_nxt;
    logic          slot_free, load, in_rdy, pkt_inc;

    // output register can take a new flit when empty or draining this cycle
    assign slot_free    = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = in_rdy;
    assign busy         = (state == BODY);

    // head flit: type, zero filler, then route fields in the low 16 bits
    always_comb begin
        head_flit                = '0;
        head_flit[DW-1:DW-2]     = T_HEAD;
        head_flit[15:0]          = {DST_X, DST_Y, SRC_X, SRC_Y};
    end

    // next-state, output-register load and payload typing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        flit_nxt  = head_flit;
        in_rdy    = 1'b0;
        pkt_inc   = 1'b0;
        case (state)
            IDLE: begin
                // head is only emitted once a word is actually waiting
                if (bus.in_valid && slot_free) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = BODY;
                end
            end
            BODY: begin
                in_rdy = slot_free;
                if (bus.in_valid && slot_free) begin
                    load = 1'b1;
                    if (cnt == LAST) begin
                        flit_nxt  = {T_TAIL, bus.in_data[DW-3:0]};
                        state_nxt = IDLE;
                        pkt_inc   = 1'b1;
                    end else begin
                        flit_nxt  = {T_BODY, bus.in_data[DW-3:0]};
                        cnt_nxt   = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and payload counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // output flit register; data holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= flit_nxt;
        end else if (slot_free) begin
            bus.out_valid <= 1'b0;
        end
    end

    // completed-packet counter, bumped on tail acceptance, wraps naturally
    always_ff @(posedge clk) begin
        if (rst)          pkt_cnt <= '0;
        else if (pkt_inc) pkt_cnt <= pkt_cnt + 16'd1;
    end

endmodule

// File: doc/pe_packetizer.md
PE_PACKETIZER -- requirements
Module: pe_packetizer

Interface
REQ-001 The block SHALL have parameter DW, default `DW: flit width in bits; legal range DW >= 18.
REQ-002 The block SHALL have parameter PKT_LEN, default `PKT_LEN: total flits per packet (1 head + PKT_LEN-1 payload); legal range PKT_LEN >= 2.
REQ-003 The block SHALL have parameters X, Y, default 0: source node coordinates (4 bits each).
REQ-004 The block SHALL have parameters DEST_X, DEST_Y, default 0: destination node coordinates (4 bits each).
REQ-005 Port: clk  input  1  sole clock; all logic on posedge.
REQ-006 Port: rst  input  1  reset, synchronous, active-high.
REQ-007 Port: in_data  input  DW  PE result word (from the PE cast_gather output).
REQ-008 Port: in_valid  input  1  in_data valid.
REQ-009 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-010 Port: out_data  output  DW  flit to the router local port.
REQ-011 Port: out_valid  output  1  out_data valid.
REQ-012 Port: out_ready  input  1  router accepts flit.
REQ-013 Port: busy  output  1  high while a packet is open (state BODY).
REQ-014 Port: pkt_cnt  output  16  number of completed packets, wraps 0xFFFF->0.

Function
REQ-015 Flit type SHALL be out_data[DW-1:DW-2]: 2'b01 head, 2'b00 body, 2'b10 tail.
REQ-016 Head flit fields SHALL be: [15:12] DEST_X, [11:8] DEST_Y, [7:4] X, [3:0] Y, all bits [DW-3:16] zero.
REQ-017 Payload flit SHALL be {type, in_data[DW-3:0]}; in_data[DW-1:DW-2] is discarded.
REQ-018 out_data/out_valid SHALL be a single output register; slot_free = ~out_valid | out_ready.
REQ-019 A flit transfers on out_valid & out_ready; out_data SHALL stay stable while out_valid & ~out_ready.
REQ-020 FSM states SHALL be IDLE and BODY; payload counter cnt counts 0..PKT_LEN-2.
REQ-021 IDLE: in_ready = 0; when in_valid & slot_free, load head flit, cnt <= 0, go BODY; no head is emitted without in_valid.
REQ-022 BODY: in_ready = slot_free; on in_valid & in_ready, load payload flit and increment cnt.
REQ-023 Payload with cnt == PKT_LEN-2 SHALL be typed tail; on its acceptance, go IDLE and increment pkt_cnt the same edge; all other payloads typed body.
REQ-024 When slot_free and no new flit is loaded, out_valid SHALL drop to 0 next cycle.
REQ-025 Latency: in_valid first high at cycle t (IDLE, slot free) -> head out_valid at t+1; that word accepted at t+1 earliest, its flit valid at t+2.
REQ-026 Sustained throughput SHALL be one flit per cycle with in_valid and out_ready continuously high; one input bubble per packet for the head.
REQ-027 in_valid gaps in BODY SHALL not close the packet; the block waits indefinitely in BODY.
REQ-028 pkt_cnt SHALL wrap from 0xFFFF to 0x0000 without side effects.

Reset
REQ-029 While rst is high at a posedge: state IDLE, cnt 0, out_valid 0, out_data 0, pkt_cnt 0, busy 0; in_ready 0 combinationally in IDLE.
REQ-030 rst in BODY SHALL abandon the open packet; no tail is emitted and pkt_cnt is not incremented.
REQ-031 rst with out_valid high SHALL drop the held flit.

Verification
REQ-032 DW=32, PKT_LEN=4, X=0, Y=0, DEST_X=2, DEST_Y=1, out_ready=1, inputs 0x11..0x16 back-to-back -> flits 0x40002100, 0x00000011, 0x00000012, 0x80000013, 0x40002100, 0x00000014, 0x00000015, 0x80000016; pkt_cnt=2.
REQ-033 Same config, out_ready low 5 cycles after the head loads -> head held stable, in_ready=0 throughout, no flit lost or duplicated after release.
REQ-034 in_valid toggling 1/0 each cycle -> identical flit sequence as REQ-032, with out_valid gaps only.
REQ-035 rst pulsed 1 cycle after the second payload is accepted -> out_valid=0 and pkt_cnt=0 next cycle; the next input starts a fresh head.
REQ-036 PKT_LEN=2, pkt_cnt preloaded to 0xFFFF via 65535 packets -> the next tail acceptance gives pkt_cnt=0x0000.
REQ-037 in_data=0xFFFFFFFF with PKT_LEN=2 -> payload flit 0xBFFFFFFF (tail type, top bits replaced).
